// File: rtl/flit_injector.sv
// Local-core flit transmitter: turns a request plus payload words into
// head/body/tail flits on the router input lane and honours portBlock.
module flit_injector #(
  parameter int flitWidth          = 12,
  parameter int routerAddressWidth = 4,
  parameter int payloadWidth       = 10,
  parameter int lenWidth           = 4,
  parameter int fifoDepth          = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [routerAddressWidth-1:0] routerAddress,
  input  logic                          reqValid,
  output logic                          reqReady,
  input  logic [routerAddressWidth-1:0] reqDest,
  input  logic [lenWidth-1:0]           reqLen,
  input  logic                          payValid,
  output logic                          payReady,
  input  logic [payloadWidth-1:0]       payData,
  output logic [flitWidth-1:0]          outFlit,
  input  logic                          portBlock,
  output logic                          pktDone
);

  localparam int ptrWidth = $clog2(fifoDepth);

  localparam logic [1:0] TYPE_NULL = 2'b00;
  localparam logic [1:0] TYPE_HEAD = 2'b10;
  localparam logic [1:0] TYPE_BODY = 2'b01;
  localparam logic [1:0] TYPE_TAIL = 2'b11;

  localparam logic [ptrWidth:0] DEPTH_CNT = (ptrWidth+1)'(fifoDepth);
  localparam logic [ptrWidth-1:0] PTR_ONE = ptrWidth'(1);
  localparam logic [ptrWidth:0] CNT_ONE = (ptrWidth+1)'(1);
  localparam logic [lenWidth:0] REM_ONE = (lenWidth+1)'(1);
  localparam logic [lenWidth:0] REM_TWO = (lenWidth+1)'(2);

  typedef enum logic [1:0] {IDLE, HEAD, PAYLOAD} state_t;

  state_t                  state, state_nxt;
  logic [payloadWidth-1:0] mem [fifoDepth];
  logic [ptrWidth-1:0]     rd_ptr, wr_ptr;
  logic [ptrWidth:0]       count;
  logic [lenWidth:0]       remaining, remaining_nxt;
  logic [flitWidth-1:0]    flit_nxt;
  logic [1:0]              flit_type;
  logic                    push, pop, fifo_empty;

  function automatic logic [flitWidth-1:0] payload_flit(input logic last,
                                                        input logic [payloadWidth-1:0] word);
    return {(last ? TYPE_TAIL : TYPE_BODY), word};
  endfunction

  assign flit_type  = outFlit[flitWidth-1 -: 2];
  assign fifo_empty = (count == '0);
  assign payReady   = (count != DEPTH_CNT);
  assign push       = payValid && payReady;
  assign reqReady   = (state == IDLE);

  always_comb begin
    state_nxt     = state;
    flit_nxt      = outFlit;
    remaining_nxt = remaining;
    pop           = 1'b0;
    pktDone       = 1'b0;
    unique case (state)
      IDLE: begin
        flit_nxt = '0;
        if (reqValid) begin
          flit_nxt      = {TYPE_HEAD, reqDest, routerAddress, 2'b00};
          remaining_nxt = {1'b0, reqLen} + REM_ONE;
          state_nxt     = HEAD;
        end
      end
      HEAD: begin
        if (!portBlock) begin
          state_nxt = PAYLOAD;
          if (fifo_empty) begin
            flit_nxt = '0;
          end else begin
            pop      = 1'b1;
            flit_nxt = payload_flit(remaining == REM_ONE, mem[rd_ptr]);
          end
        end
      end
      PAYLOAD: begin
        if (flit_type == TYPE_NULL) begin
          // A starvation null is swapped for a real word as soon as one exists.
          if (!fifo_empty) begin
            pop      = 1'b1;
            flit_nxt = payload_flit(remaining == REM_ONE, mem[rd_ptr]);
          end
        end else if (!portBlock) begin
          remaining_nxt = remaining - REM_ONE;
          if (flit_type == TYPE_TAIL) begin
            pktDone   = 1'b1;
            flit_nxt  = '0;
            state_nxt = IDLE;
          end else if (fifo_empty) begin
            flit_nxt = '0;
          end else begin
            pop      = 1'b1;
            flit_nxt = payload_flit(remaining == REM_TWO, mem[rd_ptr]);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      outFlit   <= '0;
      remaining <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else begin
      state     <= state_nxt;
      outFlit   <= flit_nxt;
      remaining <= remaining_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; only the pointers and count define contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= payData;
  end

endmodule

// File: tb/tb_flit_injector.sv
// Bench for flit_injector: directed scenarios plus randomized traffic, all
// compared cycle by cycle with a queue-based packetizer model.
module tb_flit_injector;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  routerAddress;
  logic        reqValid;
  logic        reqReady;
  logic [3:0]  reqDest;
  logic [3:0]  reqLen;
  logic        payValid;
  logic        payReady;
  logic [9:0]  payData;
  logic [11:0] outFlit;
  logic        portBlock;
  logic        pktDone;

  flit_injector dut (
    .clk(clk), .reset(reset), .routerAddress(routerAddress),
    .reqValid(reqValid), .reqReady(reqReady), .reqDest(reqDest), .reqLen(reqLen),
    .payValid(payValid), .payReady(payReady), .payData(payData),
    .outFlit(outFlit), .portBlock(portBlock), .pktDone(pktDone)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: phase 0 = idle, 1 = head on the lane, 2 = payload flits on the lane.
  int unsigned mq[$];
  logic [11:0] m_out;
  int          m_phase;
  int          m_rem;

  logic [12:0] trace[$];
  logic        pr_trace[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] take(input bit last);
    int unsigned w;
    if (mq.size() == 0) return 12'h000;
    w = mq.pop_front();
    return {(last ? 2'b11 : 2'b01), w[9:0]};
  endfunction

  task automatic model_update();
    bit push;
    if (reset) begin
      mq.delete();
      m_out = 12'h000; m_phase = 0; m_rem = 0;
      return;
    end
    push = payValid && (mq.size() < 4);
    case (m_phase)
      0: begin
        m_out = 12'h000;
        if (reqValid) begin
          m_out = {2'b10, reqDest, routerAddress, 2'b00};
          m_rem = int'(reqLen) + 1;
          m_phase = 1;
        end
      end
      1: if (!portBlock) begin
        m_phase = 2;
        m_out = take(m_rem == 1);
      end
      default: begin
        if (m_out[11:10] == 2'b00) begin
          m_out = take(m_rem == 1);
        end else if (!portBlock) begin
          if (m_out[11:10] == 2'b11) begin
            m_out = 12'h000;
            m_phase = 0;
          end else begin
            m_rem--;
            m_out = take(m_rem == 1);
          end
        end
      end
    endcase
    if (push) mq.push_back(int'(payData));
  endtask

  task automatic tick();
    logic exp_done;
    #1;
    exp_done = (m_phase == 2) && (m_out[11:10] == 2'b11) && !portBlock;
    chk("outFlit", 32'(outFlit), 32'(m_out));
    chk("reqReady", 32'(reqReady), 32'(m_phase == 0));
    chk("payReady", 32'(payReady), 32'(mq.size() < 4));
    chk("pktDone", 32'(pktDone), 32'(exp_done));
    trace.push_back({pktDone, outFlit});
    pr_trace.push_back(payReady);
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  function automatic int cnt(input logic [12:0] v);
    int n = 0;
    foreach (trace[i]) if (trace[i] == v) n++;
    return n;
  endfunction

  task automatic nonnull(output logic [11:0] nn[$]);
    nn.delete();
    foreach (trace[i]) if (trace[i][11:0] != 12'h000) nn.push_back(trace[i][11:0]);
  endtask

  task automatic push_word(input logic [9:0] w);
    payValid = 1'b1; payData = w; tick(); payValid = 1'b0;
  endtask

  task automatic request(input logic [3:0] d, input logic [3:0] l);
    reqValid = 1'b1; reqDest = d; reqLen = l; tick(); reqValid = 1'b0;
  endtask

  task automatic run_basic(input string tag);
    logic [11:0] nn[$];
    trace.delete();
    routerAddress = 4'b0110;
    push_word(10'h12B);
    push_word(10'h021);
    request(4'b0100, 4'd1);
    repeat (6) tick();
    nonnull(nn);
    chk({tag, "_nflits"}, 32'(nn.size()), 32'd3);
    if (nn.size() == 3) begin
      chk({tag, "_head"}, 32'(nn[0]), 32'b100100011000);
      chk({tag, "_body"}, 32'(nn[1]), 32'b010100101011);
      chk({tag, "_tail"}, 32'(nn[2]), 32'b110000100001);
    end
    chk({tag, "_tail_done"}, 32'(cnt({1'b1, 12'b110000100001})), 32'd1);
  endtask

  initial begin
    logic [11:0] nn[$];
    bit found;
    reset = 1'b1; routerAddress = 4'b0110; reqValid = 1'b0; reqDest = 4'h0;
    reqLen = 4'h0; payValid = 1'b0; payData = 10'h000; portBlock = 1'b0;
    m_out = 12'h000; m_phase = 0; m_rem = 0;
    repeat (2) begin @(posedge clk); model_update(); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_flit", 32'(outFlit), 32'h000);
    chk("rst_reqReady", 32'(reqReady), 32'd1);
    chk("rst_payReady", 32'(payReady), 32'd1);
    chk("rst_pktDone", 32'(pktDone), 32'd0);

    run_basic("t2");

    // Backpressure while the body flit is on the lane.
    trace.delete();
    push_word(10'h12B);
    push_word(10'h021);
    request(4'b0100, 4'd1);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (outFlit == 12'b010100101011) found = 1;
      else tick();
    end
    chk("t3_reach_body", 32'(found), 32'd1);
    portBlock = 1'b1;
    repeat (3) tick();
    portBlock = 1'b0;
    repeat (4) tick();
    chk("t3_body_cycles", 32'(cnt({1'b0, 12'b010100101011})), 32'd4);
    chk("t3_tail_once", 32'(cnt({1'b1, 12'b110000100001})), 32'd1);
    chk("t3_head_once", 32'(cnt({1'b0, 12'b100100011000})), 32'd1);

    // Starved single-flit packet.
    trace.delete();
    request(4'b0011, 4'd0);
    repeat (5) tick();
    push_word(10'h3FF);
    repeat (4) tick();
    chk("t4_tail_done", 32'(cnt({1'b1, 12'hFFF})), 32'd1);
    nonnull(nn);
    chk("t4_nflits", 32'(nn.size()), 32'd2);

    // FIFO fills; fifth word refused.
    trace.delete(); pr_trace.delete();
    for (int i = 0; i < 5; i++) push_word(10'(10'h100 + i));
    chk("t5_ready_4th", 32'(pr_trace[3]), 32'd1);
    chk("t5_full_5th", 32'(pr_trace[4]), 32'd0);
    request(4'b1001, 4'd3);
    repeat (8) tick();
    nonnull(nn);
    chk("t5_nflits", 32'(nn.size()), 32'd5);
    if (nn.size() == 5) begin
      chk("t5_w0", 32'(nn[1]), 32'h500);
      chk("t5_w1", 32'(nn[2]), 32'h501);
      chk("t5_w2", 32'(nn[3]), 32'h502);
      chk("t5_w3", 32'(nn[4]), 32'hD03);
    end

    // Reset in the middle of a packet.
    push_word(10'h155); push_word(10'h0AA); push_word(10'h2C3);
    request(4'b0001, 4'd2);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (outFlit == 12'h4AA) found = 1;
      else tick();
    end
    chk("t6_reach_body2", 32'(found), 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    #1;
    chk("t6_flit_cleared", 32'(outFlit), 32'h000);
    chk("t6_idle", 32'(reqReady), 32'd1);
    run_basic("t6");

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      reset         = ($urandom_range(0, 199) == 0);
      routerAddress = 4'($urandom);
      reqValid      = ($urandom_range(0, 3) == 0);
      reqDest       = 4'($urandom);
      reqLen        = 4'($urandom_range(0, 5));
      payValid      = ($urandom_range(0, 1) == 1);
      payData       = 10'($urandom);
      portBlock     = ($urandom_range(0, 2) == 0);
      tick();
    end
    reset = 1'b0; reqValid = 1'b0; payValid = 1'b0; portBlock = 1'b0;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
